// File: rtl/rename_map_table.sv
// Speculative register map table for the 3-wide rename stage.
// Renames sources through the map, allocates destinations and tracks ready bits.
module rename_map_table #(
    parameter int WAYS   = 3,
    parameter int AR_NUM = 32,
    parameter int PR_NUM = 64,
    parameter int CDB_N  = 3,
    parameter int AR_W   = $clog2(AR_NUM),
    parameter int PR_W   = $clog2(PR_NUM)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WAYS-1:0]        dis_valid,
    input  logic [WAYS-1:0]        dis_has_dest,
    input  logic [WAYS*AR_W-1:0]   dis_dest_ar,
    input  logic [WAYS*AR_W-1:0]   dis_src1_ar,
    input  logic [WAYS*AR_W-1:0]   dis_src2_ar,
    input  logic [WAYS*PR_W-1:0]   FreeReg,
    input  logic [WAYS-1:0]        FreeRegValid,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*PR_W-1:0]  cdb_tag,
    input  logic                   BPRecoverEN,
    input  logic [AR_NUM*PR_W-1:0] arch_map,
    output logic [WAYS*PR_W-1:0]   dis_T,
    output logic [WAYS*PR_W-1:0]   dis_Told,
    output logic [WAYS*PR_W-1:0]   src1_T,
    output logic [WAYS*PR_W-1:0]   src2_T,
    output logic [WAYS-1:0]        src1_rdy,
    output logic [WAYS-1:0]        src2_rdy,
    output logic [WAYS-1:0]        DispatchEN,
    output logic                   stall
);

    logic [PR_W-1:0]   mapQ [AR_NUM];
    logic [PR_NUM-1:0] rdyQ;
    logic [PR_NUM-1:0] rdyNext;
    logic [WAYS-1:0]   renameVec;
    logic [PR_W-1:0]   newTag [WAYS];

    function automatic logic cdbHit(input logic [PR_W-1:0] tag,
                                    input logic [CDB_N-1:0] valid,
                                    input logic [CDB_N*PR_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < CDB_N; j++)
            if (valid[j] && tags[j*PR_W +: PR_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    // Returns {bypassed, tag}; the youngest older renaming way overrides the map.
    function automatic logic [PR_W:0] resolve(input logic [AR_W-1:0] ar, input int k,
                                              input logic [WAYS-1:0] ren,
                                              input logic [WAYS*AR_W-1:0] dests,
                                              input logic [WAYS*PR_W-1:0] tags,
                                              input logic [PR_W-1:0] mapped);
        logic [PR_W:0] r;
        r = {1'b0, mapped};
        for (int j = 0; j < WAYS; j++)
            if (j < k && ren[j] && dests[j*AR_W +: AR_W] == ar) r = {1'b1, tags[j*PR_W +: PR_W]};
        return r;
    endfunction

    always_comb begin : alloc
        int used;
        used       = 0;
        renameVec  = '0;
        stall      = BPRecoverEN;
        DispatchEN = '0;
        dis_T      = '0;
        for (int k = 0; k < WAYS; k++) begin
            newTag[k]    = '0;
            renameVec[k] = dis_valid[k] & dis_has_dest[k] & (dis_dest_ar[k*AR_W +: AR_W] != '0);
            if (renameVec[k]) begin
                // Compacted slot: way k consumes the next unused free-list entry.
                for (int s = 0; s < WAYS; s++) begin
                    if (s == used) begin
                        newTag[k] = FreeReg[s*PR_W +: PR_W];
                        if (!FreeRegValid[s]) stall = 1'b1;
                    end
                end
                used++;
            end
            dis_T[k*PR_W +: PR_W] = newTag[k];
        end
        for (int s = 0; s < WAYS; s++) DispatchEN[s] = !stall && (s < used);
    end

    always_comb begin : lookup
        logic [AR_W-1:0] a1, a2, ad;
        logic [PR_W:0]   r1, r2, ro;
        src1_T   = '0;
        src2_T   = '0;
        src1_rdy = '0;
        src2_rdy = '0;
        dis_Told = '0;
        for (int k = 0; k < WAYS; k++) begin
            a1 = dis_src1_ar[k*AR_W +: AR_W];
            a2 = dis_src2_ar[k*AR_W +: AR_W];
            ad = dis_dest_ar[k*AR_W +: AR_W];
            r1 = resolve(a1, k, renameVec, dis_dest_ar, dis_T, mapQ[a1]);
            r2 = resolve(a2, k, renameVec, dis_dest_ar, dis_T, mapQ[a2]);
            ro = resolve(ad, k, renameVec, dis_dest_ar, dis_T, mapQ[ad]);
            src1_T[k*PR_W +: PR_W] = r1[PR_W-1:0];
            src2_T[k*PR_W +: PR_W] = r2[PR_W-1:0];
            src1_rdy[k] = !r1[PR_W] && (rdyQ[r1[PR_W-1:0]] || cdbHit(r1[PR_W-1:0], cdb_valid, cdb_tag));
            src2_rdy[k] = !r2[PR_W] && (rdyQ[r2[PR_W-1:0]] || cdbHit(r2[PR_W-1:0], cdb_valid, cdb_tag));
            // AR 0 is hardwired: tag 0, always ready, regardless of the map contents.
            if (a1 == '0) begin
                src1_T[k*PR_W +: PR_W] = '0;
                src1_rdy[k]            = 1'b1;
            end
            if (a2 == '0) begin
                src2_T[k*PR_W +: PR_W] = '0;
                src2_rdy[k]            = 1'b1;
            end
            dis_Told[k*PR_W +: PR_W] = ro[PR_W-1:0];
        end
    end

    always_comb begin : readyUpdate
        rdyNext = rdyQ;
        for (int j = 0; j < CDB_N; j++)
            if (cdb_valid[j]) rdyNext[cdb_tag[j*PR_W +: PR_W]] = 1'b1;
        // Allocation clears after CDB sets so a fresh tag is never seen ready.
        if (!stall)
            for (int k = 0; k < WAYS; k++)
                if (renameVec[k]) rdyNext[newTag[k]] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < AR_NUM; r++) mapQ[r] <= PR_W'(r);
            rdyQ <= '1;
        end else if (BPRecoverEN) begin
            for (int r = 0; r < AR_NUM; r++) mapQ[r] <= arch_map[r*PR_W +: PR_W];
            rdyQ <= '1;
        end else begin
            rdyQ <= rdyNext;
            if (!stall)
                for (int k = 0; k < WAYS; k++)
                    if (renameVec[k]) mapQ[dis_dest_ar[k*AR_W +: AR_W]] <= newTag[k];
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: hand-computed rename, bypass, CDB,
// stall, recovery and reset vectors checked with immediate assertions.
module tb_rename_map_table;
    localparam int WAYS = 3, AR_NUM = 32, PR_NUM = 64, CDB_N = 3, AR_W = 5, PR_W = 6;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [WAYS-1:0]        dis_valid, dis_has_dest;
    logic [WAYS*AR_W-1:0]   dis_dest_ar, dis_src1_ar, dis_src2_ar;
    logic [WAYS*PR_W-1:0]   FreeReg;
    logic [WAYS-1:0]        FreeRegValid;
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*PR_W-1:0]  cdb_tag;
    logic                   BPRecoverEN;
    logic [AR_NUM*PR_W-1:0] arch_map;
    logic [WAYS*PR_W-1:0]   dis_T, dis_Told, src1_T, src2_T;
    logic [WAYS-1:0]        src1_rdy, src2_rdy, DispatchEN;
    logic                   stall;

    int vectors = 0;
    int miscompares = 0;

    rename_map_table #(.WAYS(WAYS), .AR_NUM(AR_NUM), .PR_NUM(PR_NUM), .CDB_N(CDB_N)) dut (
        .clock(clock), .reset(reset), .dis_valid(dis_valid), .dis_has_dest(dis_has_dest),
        .dis_dest_ar(dis_dest_ar), .dis_src1_ar(dis_src1_ar), .dis_src2_ar(dis_src2_ar),
        .FreeReg(FreeReg), .FreeRegValid(FreeRegValid), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .BPRecoverEN(BPRecoverEN), .arch_map(arch_map), .dis_T(dis_T), .dis_Told(dis_Told),
        .src1_T(src1_T), .src2_T(src2_T), .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
        .DispatchEN(DispatchEN), .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clearIns();
        dis_valid = '0; dis_has_dest = '0; dis_dest_ar = '0;
        dis_src1_ar = '0; dis_src2_ar = '0; cdb_valid = '0; cdb_tag = '0;
    endtask

    task automatic setWay(input int k, input logic hasDest, input int dest, input int s1, input int s2);
        dis_valid[k] = 1'b1;
        dis_has_dest[k] = hasDest;
        dis_dest_ar[k*AR_W +: AR_W] = AR_W'(dest);
        dis_src1_ar[k*AR_W +: AR_W] = AR_W'(s1);
        dis_src2_ar[k*AR_W +: AR_W] = AR_W'(s2);
    endtask

    task automatic setFree(input int f0, input int f1, input int f2, input logic [2:0] v);
        FreeReg = {PR_W'(f2), PR_W'(f1), PR_W'(f0)};
        FreeRegValid = v;
    endtask

    function automatic int tT(input int k);  return int'(dis_T[k*PR_W +: PR_W]);    endfunction
    function automatic int tO(input int k);  return int'(dis_Told[k*PR_W +: PR_W]); endfunction
    function automatic int t1(input int k);  return int'(src1_T[k*PR_W +: PR_W]);   endfunction
    function automatic int t2(input int k);  return int'(src2_T[k*PR_W +: PR_W]);   endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; BPRecoverEN = 1'b0; arch_map = '0;
        clearIns();
        setFree(40, 41, 42, 3'b111);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state lookup
        setWay(0, 1'b0, 0, 5, 0);
        #1;
        check("rst_src1_T", t1(0), 5);
        check("rst_src1_rdy", int'(src1_rdy[0]), 1);
        check("rst_src2_T_ar0", t2(0), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_dispen", int'(DispatchEN), 0);

        // Single rename of r3
        clearIns(); setWay(0, 1'b1, 3, 1, 2);
        #1;
        check("r3_disT0", tT(0), 40);
        check("r3_Told0", tO(0), 3);
        check("r3_dispen", int'(DispatchEN), 1);
        check("r3_disT1_none", tT(1), 0);
        tick();

        clearIns(); setWay(0, 1'b0, 0, 3, 0);
        #1;
        check("r3_next_T", t1(0), 40);
        check("r3_next_rdy", int'(src1_rdy[0]), 0);

        // Intra-group bypass, two writers of r7
        clearIns(); setFree(43, 44, 45, 3'b111);
        setWay(0, 1'b1, 7, 1, 2);
        setWay(1, 1'b1, 7, 7, 0);
        setWay(2, 1'b0, 0, 7, 3);
        #1;
        check("grp_w1_src1_T", t1(1), 43);
        check("grp_w1_src1_rdy", int'(src1_rdy[1]), 0);
        check("grp_w1_Told", tO(1), 43);
        check("grp_w1_disT", tT(1), 44);
        check("grp_w0_Told", tO(0), 7);
        check("grp_w2_src1_T", t1(2), 44);
        check("grp_w2_src2_T", t2(2), 40);
        check("grp_dispen", int'(DispatchEN), 3);
        tick();

        // Same-cycle CDB bypass on pending tag 44
        clearIns(); setWay(0, 1'b0, 0, 7, 0); setWay(1, 1'b0, 0, 3, 0);
        cdb_valid = 3'b001; cdb_tag = {6'd0, 6'd0, 6'd44};
        #1;
        check("cdb_src_T", t1(0), 44);
        check("cdb_src_rdy", int'(src1_rdy[0]), 1);
        check("cdb_other_rdy", int'(src1_rdy[1]), 0);
        tick();
        cdb_valid = '0;
        #1;
        check("cdb_after_rdy", int'(src1_rdy[0]), 1);

        // Stall: three renames, only two free slots valid
        clearIns(); setFree(50, 51, 52, 3'b011);
        setWay(0, 1'b1, 1, 0, 0); setWay(1, 1'b1, 2, 0, 0); setWay(2, 1'b1, 4, 0, 0);
        #1;
        check("stall_flag", int'(stall), 1);
        check("stall_dispen", int'(DispatchEN), 0);
        tick();
        clearIns(); setWay(0, 1'b0, 0, 1, 4);
        #1;
        check("stall_nomap_s1", t1(0), 1);
        check("stall_nomap_s2", t2(0), 4);
        check("stall_nomap_rdy", int'(src1_rdy[0]), 1);

        // Compaction: r0 dest not renamed, way2 takes slot 0
        clearIns(); setFree(50, 51, 52, 3'b001);
        setWay(0, 1'b1, 0, 0, 0); setWay(2, 1'b1, 9, 0, 0);
        #1;
        check("cmp_disT2", tT(2), 50);
        check("cmp_disT0", tT(0), 0);
        check("cmp_dispen", int'(DispatchEN), 1);
        check("cmp_stall", int'(stall), 0);
        tick();

        // Allocation clear beats CDB set on the same tag
        clearIns(); setFree(46, 47, 48, 3'b111);
        setWay(0, 1'b1, 10, 9, 0);
        cdb_valid = 3'b010; cdb_tag = {6'd0, 6'd46, 6'd0};
        #1;
        check("clr_src_r9", t1(0), 50);
        tick();
        clearIns(); setWay(0, 1'b0, 0, 10, 9);
        #1;
        check("clr_r10_T", t1(0), 46);
        check("clr_r10_rdy", int'(src1_rdy[0]), 0);
        check("clr_r9_rdy", int'(src2_rdy[0]), 0);

        // Branch recovery from arch_map[r]=r+32
        for (int r = 0; r < AR_NUM; r++) arch_map[r*PR_W +: PR_W] = PR_W'(r + 32);
        clearIns(); setWay(0, 1'b1, 5, 0, 0);
        BPRecoverEN = 1'b1;
        #1;
        check("rec_stall", int'(stall), 1);
        check("rec_dispen", int'(DispatchEN), 0);
        tick();
        BPRecoverEN = 1'b0;
        clearIns(); setWay(0, 1'b0, 0, 4, 10); setWay(1, 1'b0, 0, 0, 5);
        #1;
        check("rec_r4_T", t1(0), 36);
        check("rec_r4_rdy", int'(src1_rdy[0]), 1);
        check("rec_r10_T", t2(0), 42);
        check("rec_r10_rdy", int'(src2_rdy[0]), 1);
        check("rec_r0_T", t1(1), 0);
        check("rec_r5_T", t2(1), 37);

        // Asynchronous reset mid-run
        #2 reset = 1'b1;
        #1;
        check("arst_r4_T", t1(0), 4);
        check("arst_r10_T", t2(0), 10);
        check("arst_r5_T", t2(1), 5);
        tick();
        reset = 1'b0;
        #1;
        check("arst_hold_r4", t1(0), 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
